// File: rtl/sram_port0_arbiter.sv
// Two-requester arbiter and command sequencer for the RW port of the 32x256 OpenRAM macro.
// A has priority, B is protected by a starvation limit; fixed 2-cycle read latency.
module sram_port0_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned NUM_WMASKS   = 4,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // requester A
  input  logic                  a_req_valid,
  output logic                  a_req_ready,
  input  logic                  a_req_we,
  input  logic [NUM_WMASKS-1:0] a_req_wmask,
  input  logic [ADDR_WIDTH-1:0] a_req_addr,
  input  logic [DATA_WIDTH-1:0] a_req_wdata,
  output logic                  a_rsp_valid,
  output logic [DATA_WIDTH-1:0] a_rsp_rdata,
  // requester B
  input  logic                  b_req_valid,
  output logic                  b_req_ready,
  input  logic                  b_req_we,
  input  logic [NUM_WMASKS-1:0] b_req_wmask,
  input  logic [ADDR_WIDTH-1:0] b_req_addr,
  input  logic [DATA_WIDTH-1:0] b_req_wdata,
  output logic                  b_rsp_valid,
  output logic [DATA_WIDTH-1:0] b_rsp_rdata,
  // macro port 0
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0
);

  localparam int unsigned CntW = 4;
  localparam logic [CntW-1:0] Limit = CntW'(STARVE_LIMIT);

  logic [CntW-1:0]       starve_q, starve_d;
  logic                  grant_a, grant_b, hs;
  logic                  sel_we;
  logic [NUM_WMASKS-1:0] sel_wmask;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  logic                  csb_q, csb_d, web_q, web_d;
  logic [NUM_WMASKS-1:0] wmask_q, wmask_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic                  rd1_q, rd1_d, own1_q, own1_d;
  logic                  a_rsp_q, a_rsp_d, b_rsp_q, b_rsp_d;

  // Arbitration, request mux and starvation counter
  always_comb begin
    grant_b   = b_req_valid & (~a_req_valid | (starve_q == Limit));
    grant_a   = a_req_valid & ~grant_b;
    hs        = grant_a | grant_b;
    sel_we    = grant_b ? b_req_we    : a_req_we;
    sel_wmask = grant_b ? b_req_wmask : a_req_wmask;
    sel_addr  = grant_b ? b_req_addr  : a_req_addr;
    sel_wdata = grant_b ? b_req_wdata : a_req_wdata;
    starve_d  = '0;
    if (b_req_valid && !grant_b) begin
      starve_d = (starve_q == Limit) ? starve_q : starve_q + CntW'(1);
    end
  end

  // Command stage and owner-tag pipeline
  always_comb begin
    csb_d   = ~hs;
    web_d   = ~(hs & sel_we);
    wmask_d = wmask_q;
    addr_d  = addr_q;
    din_d   = din_q;
    if (hs) begin
      wmask_d = sel_we ? sel_wmask : '0;
      addr_d  = sel_addr;
      din_d   = sel_wdata;
    end
    rd1_d   = hs & ~sel_we;
    own1_d  = grant_b;
    a_rsp_d = rd1_q & ~own1_q;
    b_rsp_d = rd1_q & own1_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_q <= '0;
      csb_q    <= 1'b1;
      web_q    <= 1'b1;
      wmask_q  <= '0;
      addr_q   <= '0;
      din_q    <= '0;
      rd1_q    <= 1'b0;
      own1_q   <= 1'b0;
      a_rsp_q  <= 1'b0;
      b_rsp_q  <= 1'b0;
    end else begin
      starve_q <= starve_d;
      csb_q    <= csb_d;
      web_q    <= web_d;
      wmask_q  <= wmask_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      rd1_q    <= rd1_d;
      own1_q   <= own1_d;
      a_rsp_q  <= a_rsp_d;
      b_rsp_q  <= b_rsp_d;
    end
  end

  assign a_req_ready = grant_a;
  assign b_req_ready = grant_b;
  assign sram_csb0   = csb_q;
  assign sram_web0   = web_q;
  assign sram_wmask0 = wmask_q;
  assign sram_addr0  = addr_q;
  assign sram_din0   = din_q;
  assign a_rsp_valid = a_rsp_q;
  assign b_rsp_valid = b_rsp_q;
  // Read data is the macro output passed straight through to both requesters
  assign a_rsp_rdata = sram_dout0;
  assign b_rsp_rdata = sram_dout0;

endmodule
